// File: rtl/pipe_stage_ctrl_if.sv
// Handshake/bus bundle between the datapath and pipe_stage_ctrl.
// Optional perf counters appear when PIPE_PERF_EN is defined.
interface pipe_stage_ctrl_if #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int REGW  = 5
);
    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic [REGW-1:0]         in_rs;
    logic [REGW-1:0]         in_rt;
    logic [REGW-1:0]         in_rd;
    logic                    in_wen;
    logic                    in_load;
    logic                    ihit;
    logic                    dwait;
    logic [DEPTH-1:0]        flush_mask;
    logic                    in_ready;
    logic [DEPTH-1:0]        stage_valid;
    logic [DEPTH*WIDTH-1:0]  stage_data;
    logic [DEPTH*REGW-1:0]   stage_rd;
    logic                    hz_stall;
    logic                    retire;
`ifdef PIPE_PERF_EN
    logic [31:0]             perf_retired;
    logic [31:0]             perf_freeze;
    logic [31:0]             perf_bubble;
`endif

    modport master (
        output in_valid, in_data, in_rs, in_rt, in_rd, in_wen, in_load,
               ihit, dwait, flush_mask,
        input  in_ready, stage_valid, stage_data, stage_rd, hz_stall, retire
`ifdef PIPE_PERF_EN
             , perf_retired, perf_freeze, perf_bubble
`endif
    );

    modport slave (
        input  in_valid, in_data, in_rs, in_rt, in_rd, in_wen, in_load,
               ihit, dwait, flush_mask,
        output in_ready, stage_valid, stage_data, stage_rd, hz_stall, retire
`ifdef PIPE_PERF_EN
             , perf_retired, perf_freeze, perf_bubble
`endif
    );
endinterface

// File: rtl/pipe_stage_ctrl.sv
// Pipeline-register chain with valid bits, global freeze, load-use bubble and sticky flush.
// Optional PIPE_PERF_EN adds retire/freeze/bubble event counters.
module pipe_stage_ctrl #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int REGW  = 5
) (
    input  logic                 CLK,
    input  logic                 RST,
    pipe_stage_ctrl_if.slave     bus
);
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] data;
        logic [REGW-1:0]  rs;
        logic [REGW-1:0]  rt;
        logic [REGW-1:0]  rd;
        logic             wen;
        logic             load;
    } rec_t;

    rec_t             rec_q [DEPTH];
    rec_t             rec_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    rec_t             in_rec;
    logic             freeze;
    logic [DEPTH-1:0] eff_flush;
    logic             hz;
    logic             hz_eff;

    // Hazard detection and freeze/flush qualification
    always_comb begin
        freeze    = ~bus.ihit | bus.dwait;
        eff_flush = bus.flush_mask | pend_q;
        hz = rec_q[0].valid & rec_q[1].valid & rec_q[1].load & rec_q[1].wen
           & (rec_q[1].rd != {REGW{1'b0}})
           & ((rec_q[1].rd == rec_q[0].rs) | (rec_q[1].rd == rec_q[0].rt));
        hz_eff = ~freeze & hz & ~eff_flush[0] & ~eff_flush[1];
        if (bus.in_valid) begin
            in_rec = '{valid: 1'b1, data: bus.in_data, rs: bus.in_rs, rt: bus.in_rt,
                       rd: bus.in_rd, wen: bus.in_wen, load: bus.in_load};
        end else begin
            in_rec = '0;
        end
    end

    // Next-state: hold on freeze (accumulating flushes), else shift with flush/bubble priority
    always_comb begin
        rec_d  = rec_q;
        pend_d = pend_q;
        if (freeze) begin
            pend_d = pend_q | bus.flush_mask;
        end else begin
            pend_d = {DEPTH{1'b0}};
            for (int i = 1; i < DEPTH; i++) begin
                if (eff_flush[i]) begin
                    rec_d[i] = '0;
                end else if ((i == 1) && hz_eff) begin
                    rec_d[i] = '0;
                end else begin
                    rec_d[i] = rec_q[i-1];
                end
            end
            if (eff_flush[0]) begin
                rec_d[0] = '0;
            end else if (hz_eff) begin
                rec_d[0] = rec_q[0];
            end else begin
                rec_d[0] = in_rec;
            end
        end
    end

    // Stage registers and sticky flush mask
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                rec_q[i] <= '0;
            end
            pend_q <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                rec_q[i] <= rec_d[i];
            end
            pend_q <= pend_d;
        end
    end

    // Output unpacking; in_ready is gated by RST so fetch never sees a grant during reset
    always_comb begin
        bus.stage_valid = {DEPTH{1'b0}};
        bus.stage_data  = {(DEPTH*WIDTH){1'b0}};
        bus.stage_rd    = {(DEPTH*REGW){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            bus.stage_valid[i]              = rec_q[i].valid;
            bus.stage_data[i*WIDTH +: WIDTH] = rec_q[i].data;
            bus.stage_rd[i*REGW +: REGW]     = rec_q[i].rd;
        end
        bus.in_ready = ~RST & ~freeze & ~hz_eff & ~eff_flush[0];
        bus.hz_stall = hz_eff;
        bus.retire   = ~freeze & rec_q[DEPTH-1].valid;
    end

`ifdef PIPE_PERF_EN
    logic [31:0] perf_ret_q;
    logic [31:0] perf_frz_q;
    logic [31:0] perf_bub_q;

    // Free-running wrap-around event counters
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            perf_ret_q <= 32'd0;
            perf_frz_q <= 32'd0;
            perf_bub_q <= 32'd0;
        end else begin
            perf_ret_q <= perf_ret_q + {31'd0, bus.retire};
            perf_frz_q <= perf_frz_q + {31'd0, freeze};
            perf_bub_q <= perf_bub_q + {31'd0, hz_eff};
        end
    end

    assign bus.perf_retired = perf_ret_q;
    assign bus.perf_freeze  = perf_frz_q;
    assign bus.perf_bubble  = perf_bub_q;
`endif
endmodule

// File: tb/tb_pipe_stage_ctrl.sv
// Self-checking bench for pipe_stage_ctrl (DEPTH=4): directed scenarios plus a randomized run
// against a behavioural model of the stage records.
module tb_pipe_stage_ctrl;
    localparam int DEPTH = 4;
    localparam int WIDTH = 64;
    localparam int REGW  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pipe_stage_ctrl_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .REGW(REGW)) bus ();
    pipe_stage_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH), .REGW(REGW)) dut (
        .CLK(clk), .RST(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic [63:0] d;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        wen;
        logic        ld;
    } mrec_t;

    function automatic logic [63:0] sd(input int i);
        return bus.stage_data[i*WIDTH +: WIDTH];
    endfunction

    function automatic logic [4:0] srd(input int i);
        return bus.stage_rd[i*REGW +: REGW];
    endfunction

    task automatic set_in(input logic v, input logic [63:0] d, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd, input logic wen,
                          input logic ld);
        bus.in_valid = v; bus.in_data = d; bus.in_rs = rs; bus.in_rt = rt;
        bus.in_rd = rd; bus.in_wen = wen; bus.in_load = ld;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_in(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        bus.ihit = 1'b1; bus.dwait = 1'b0; bus.flush_mask = 4'b0000;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        set_in(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        bus.ihit = 1'b1; bus.dwait = 1'b0; bus.flush_mask = 4'b0000;
        #2;
        checks++; if (bus.stage_valid !== 4'b0000) begin failures++; $display("FAIL reset_valid got=%b exp=0000", bus.stage_valid); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.retire !== 1'b0 || bus.hz_stall !== 1'b0) begin failures++; $display("FAIL reset_retire_hz got=%b%b exp=00", bus.retire, bus.hz_stall); end
        checks++; if (bus.stage_data !== '0 || bus.stage_rd !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.stage_data); end
`ifdef PIPE_PERF_EN
        checks++; if (bus.perf_retired !== 32'd0 || bus.perf_freeze !== 32'd0 || bus.perf_bubble !== 32'd0) begin failures++; $display("FAIL reset_perf got=%0d/%0d/%0d exp=0", bus.perf_retired, bus.perf_freeze, bus.perf_bubble); end
`endif
    endtask

    task automatic test_stream();
        int nret;
        nret = 0;
        do_reset();
        for (int t = 0; t < 10; t++) begin
            if (t < 6) set_in(1'b1, 64'(t + 1), 5'd0, 5'd0, 5'(t + 1), 1'b1, 1'b0);
            else       set_in(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            #1;
            if (t < 6) begin
                checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL stream_ready t=%0d got=%b exp=1", t, bus.in_ready); end
            end
            checks++; if (bus.retire !== (t >= 4)) begin failures++; $display("FAIL stream_retire t=%0d got=%b exp=%b", t, bus.retire, (t >= 4)); end
            if (t >= 4) begin
                nret++;
                checks++; if (sd(3) !== 64'(t - 3)) begin failures++; $display("FAIL stream_retire_data t=%0d got=%0d exp=%0d", t, sd(3), t - 3); end
            end
            adv();
            if (t >= 3 && t <= 8) begin
                checks++; if (bus.stage_valid[3] !== 1'b1 || sd(3) !== 64'(t - 2)) begin failures++; $display("FAIL stream_stage3 t=%0d got=%b/%0d exp=1/%0d", t, bus.stage_valid[3], sd(3), t - 2); end
            end
        end
        checks++; if (nret != 6 || bus.stage_valid !== 4'b0000) begin failures++; $display("FAIL stream_count got=%0d/%b exp=6/0000", nret, bus.stage_valid); end
    endtask

    task automatic test_freeze();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            set_in(1'b1, 64'(k), 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
            adv();
        end
        set_in(1'b1, 64'd4, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
        bus.ihit = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (bus.in_ready !== 1'b0 || bus.retire !== 1'b0 || bus.hz_stall !== 1'b0) begin failures++; $display("FAIL freeze_ctrl c=%0d got=%b%b%b exp=000", c, bus.in_ready, bus.retire, bus.hz_stall); end
            adv();
            checks++; if (bus.stage_valid !== 4'b0111 || sd(0) !== 64'd3 || sd(1) !== 64'd2 || sd(2) !== 64'd1) begin failures++; $display("FAIL freeze_hold c=%0d got=%b %0d %0d %0d exp=0111 3 2 1", c, bus.stage_valid, sd(0), sd(1), sd(2)); end
        end
        bus.ihit = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL freeze_resume_ready got=%b exp=1", bus.in_ready); end
        adv();
        checks++; if (bus.stage_valid !== 4'b1111 || sd(0) !== 64'd4 || sd(3) !== 64'd1) begin failures++; $display("FAIL freeze_resume got=%b %0d %0d exp=1111 4 1", bus.stage_valid, sd(0), sd(3)); end
    endtask

    task automatic test_hazard();
        do_reset();
        set_in(1'b1, 64'd10, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
        adv();
        set_in(1'b1, 64'd11, 5'd5, 5'd0, 5'd7, 1'b1, 1'b0);
        adv();
        set_in(1'b1, 64'd12, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
        #1;
        checks++; if (bus.hz_stall !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL hazard_detect got=%b%b exp=10", bus.hz_stall, bus.in_ready); end
        adv();
        checks++; if (bus.stage_valid !== 4'b0101 || sd(0) !== 64'd11 || sd(2) !== 64'd10 || srd(2) !== 5'd5) begin failures++; $display("FAIL hazard_bubble got=%b %0d %0d %0d exp=0101 11 10 5", bus.stage_valid, sd(0), sd(2), srd(2)); end
        checks++; if (bus.hz_stall !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL hazard_release got=%b%b exp=01", bus.hz_stall, bus.in_ready); end
        adv();
        checks++; if (sd(0) !== 64'd12 || sd(1) !== 64'd11 || bus.stage_valid !== 4'b1011) begin failures++; $display("FAIL hazard_resume got=%b %0d %0d exp=1011 12 11", bus.stage_valid, sd(0), sd(1)); end
        // rd = 0 never creates a dependency
        do_reset();
        set_in(1'b1, 64'd20, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        adv();
        set_in(1'b1, 64'd21, 5'd0, 5'd0, 5'd7, 1'b1, 1'b0);
        adv();
        set_in(1'b1, 64'd22, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
        #1;
        checks++; if (bus.hz_stall !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL hazard_rd0 got=%b%b exp=01", bus.hz_stall, bus.in_ready); end
        adv();
        checks++; if (bus.stage_valid !== 4'b0111 || sd(0) !== 64'd22 || sd(2) !== 64'd20) begin failures++; $display("FAIL hazard_rd0_flow got=%b %0d %0d exp=0111 22 20", bus.stage_valid, sd(0), sd(2)); end
    endtask

    task automatic test_flush_freeze();
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            set_in(1'b1, 64'(k), 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
            adv();
        end
        set_in(1'b1, 64'd9, 5'd0, 5'd0, 5'd1, 1'b1, 1'b0);
        bus.dwait = 1'b1; bus.flush_mask = 4'b0011;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flushfrz_ready got=%b exp=0", bus.in_ready); end
        adv();
        bus.flush_mask = 4'b0000;
        adv();
        checks++; if (bus.stage_valid !== 4'b0111 || sd(0) !== 64'd3 || sd(1) !== 64'd2) begin failures++; $display("FAIL flushfrz_hold got=%b %0d %0d exp=0111 3 2", bus.stage_valid, sd(0), sd(1)); end
        bus.dwait = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL flushfrz_pend_ready got=%b exp=0", bus.in_ready); end
        adv();
        checks++; if (bus.stage_valid !== 4'b1100 || sd(2) !== 64'd2 || sd(3) !== 64'd1) begin failures++; $display("FAIL flushfrz_apply got=%b %0d %0d exp=1100 2 1", bus.stage_valid, sd(2), sd(3)); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flushfrz_cleared got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_flush_hazard();
        do_reset();
        set_in(1'b1, 64'd10, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1);
        adv();
        set_in(1'b1, 64'd11, 5'd0, 5'd5, 5'd7, 1'b1, 1'b0);
        adv();
        set_in(1'b1, 64'd12, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0);
        bus.flush_mask = 4'b0010;
        #1;
        checks++; if (bus.hz_stall !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL flushhz_ctrl got=%b%b exp=01", bus.hz_stall, bus.in_ready); end
        adv();
        bus.flush_mask = 4'b0000;
        checks++; if (bus.stage_valid !== 4'b0101 || sd(0) !== 64'd12 || sd(2) !== 64'd10) begin failures++; $display("FAIL flushhz_state got=%b %0d %0d exp=0101 12 10", bus.stage_valid, sd(0), sd(2)); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            set_in(1'b1, 64'(k), 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
            adv();
        end
        checks++; if (bus.stage_valid !== 4'b1111) begin failures++; $display("FAIL rstmid_fill got=%b exp=1111", bus.stage_valid); end
        set_in(1'b0, 64'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.stage_valid !== 4'b0000 || bus.in_ready !== 1'b0 || bus.retire !== 1'b0) begin failures++; $display("FAIL rstmid_async got=%b %b %b exp=0000 0 0", bus.stage_valid, bus.in_ready, bus.retire); end
`ifdef PIPE_PERF_EN
        checks++; if (bus.perf_retired !== 32'd0 || bus.perf_freeze !== 32'd0 || bus.perf_bubble !== 32'd0) begin failures++; $display("FAIL rstmid_perf got=%0d/%0d/%0d exp=0", bus.perf_retired, bus.perf_freeze, bus.perf_bubble); end
`endif
        adv();
        rst = 1'b0;
        set_in(1'b1, 64'd77, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rstmid_ready got=%b exp=1", bus.in_ready); end
        adv();
        checks++; if (bus.stage_valid !== 4'b0001 || sd(0) !== 64'd77 || srd(0) !== 5'd3) begin failures++; $display("FAIL rstmid_refill got=%b %0d %0d exp=0001 77 3", bus.stage_valid, sd(0), srd(0)); end
    endtask

    task automatic test_random();
        mrec_t m [4];
        mrec_t nm [4];
        mrec_t inr;
        logic [3:0] pend, eff, fm;
        logic frz, hz, hz_eff, e_ready, e_retire;
        logic [3:0] e_valid;
        int n_ret, n_frz, n_bub;
        do_reset();
        for (int i = 0; i < 4; i++) m[i] = '0;
        pend = 4'b0000; n_ret = 0; n_frz = 0; n_bub = 0;
        for (int c = 0; c < 800; c++) begin
            set_in($urandom_range(0, 3) != 0, {$urandom, $urandom}, 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
            bus.ihit = $urandom_range(0, 7) != 0;
            bus.dwait = $urandom_range(0, 7) == 0;
            fm = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
            bus.flush_mask = fm;
            #1;
            frz = !bus.ihit || bus.dwait;
            eff = fm | pend;
            hz = m[0].v && m[1].v && m[1].ld && m[1].wen && (m[1].rd != 5'd0)
                 && (m[1].rd == m[0].rs || m[1].rd == m[0].rt);
            hz_eff = !frz && hz && !eff[0] && !eff[1];
            e_ready = !frz && !hz_eff && !eff[0];
            e_retire = !frz && m[3].v;
            for (int i = 0; i < 4; i++) e_valid[i] = m[i].v;
            checks++; if (bus.in_ready !== e_ready) begin failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, bus.in_ready, e_ready); end
            checks++; if (bus.hz_stall !== hz_eff) begin failures++; $display("FAIL rnd_hz c=%0d got=%b exp=%b", c, bus.hz_stall, hz_eff); end
            checks++; if (bus.retire !== e_retire) begin failures++; $display("FAIL rnd_retire c=%0d got=%b exp=%b", c, bus.retire, e_retire); end
            checks++; if (bus.stage_valid !== e_valid) begin failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, bus.stage_valid, e_valid); end
            for (int i = 0; i < 4; i++) begin
                checks++; if (sd(i) !== m[i].d || srd(i) !== m[i].rd) begin failures++; $display("FAIL rnd_stage%0d c=%0d got=%h/%0d exp=%h/%0d", i, c, sd(i), srd(i), m[i].d, m[i].rd); end
            end
            inr = bus.in_valid ? '{v: 1'b1, d: bus.in_data, rs: bus.in_rs, rt: bus.in_rt,
                                   rd: bus.in_rd, wen: bus.in_wen, ld: bus.in_load} : '0;
            @(posedge clk);
            n_ret += int'(e_retire); n_frz += int'(frz); n_bub += int'(hz_eff);
            if (frz) begin
                pend = pend | fm;
            end else begin
                pend = 4'b0000;
                for (int i = 1; i < 4; i++) nm[i] = (eff[i] || (i == 1 && hz_eff)) ? '0 : m[i-1];
                nm[0] = eff[0] ? '0 : (hz_eff ? m[0] : inr);
                m = nm;
            end
            #1;
        end
`ifdef PIPE_PERF_EN
        checks++; if (bus.perf_retired !== 32'(n_ret) || bus.perf_freeze !== 32'(n_frz) || bus.perf_bubble !== 32'(n_bub)) begin failures++; $display("FAIL rnd_perf got=%0d/%0d/%0d exp=%0d/%0d/%0d", bus.perf_retired, bus.perf_freeze, bus.perf_bubble, n_ret, n_frz, n_bub); end
`endif
        checks++; if (n_ret == 0 || n_bub == 0) begin failures++; $display("FAIL rnd_coverage got=%0d/%0d exp=nonzero", n_ret, n_bub); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_freeze();
        test_hazard();
        test_flush_freeze();
        test_flush_hazard();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
